// File: rtl/ps2_scancode_rx.sv
// PS/2 device-to-host receiver: conditions the raw lines, deframes 11-bit frames
// and folds E0/F0 prefixes (and the E1 Pause sequence) into one {ext, brk, byte} event.
module ps2_scancode_rx #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 50000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic       code_ready,
  output logic [9:0] scancode,
  output logic       frame_err
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [FW-1:0] F_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 2);

  // IDLE: await start bit | DATA: 8 bits LSB first | PARITY | STOP: then byte step
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t        state_q, state_d;
  logic [1:0]    clk_sync_q, dat_sync_q;
  logic          filt_q, filt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [2:0]    bcnt_q, bcnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d, stop_q, stop_d, done_q, done_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          ext_q, ext_d, brk_q, brk_d;
  logic [2:0]    skip_q, skip_d;
  logic [9:0]    code_q, code_d;
  logic          rdy_q, rdy_d, err_q, err_d;
  logic          fe, tmo, frame_ok;

  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (clk_sync_q[1] != filt_q) begin
      if (fcnt_q == F_LAST) filt_d = ~filt_q;
      else                  fcnt_d = fcnt_q + 1'b1;
    end
  end

  assign fe       = filt_q & ~filt_d;
  assign tmo      = (state_q != IDLE) && (tcnt_q == T_LAST);
  assign frame_ok = stop_q & (^{shift_q, par_q});

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
    par_d   = par_q;
    stop_d  = stop_q;
    done_d  = 1'b0;
    tcnt_d  = tcnt_q + 1'b1;
    ext_d   = ext_q;
    brk_d   = brk_q;
    skip_d  = skip_q;
    code_d  = code_q;
    rdy_d   = 1'b0;
    err_d   = 1'b0;
    if (state_q == IDLE || fe) tcnt_d = '0;
    if (tmo) begin
      state_d = IDLE;
      tcnt_d  = '0;
      err_d   = 1'b1;
      ext_d   = 1'b0;
      brk_d   = 1'b0;
      skip_d  = '0;
    end else if (fe) begin
      case (state_q)
        IDLE: if (!dat_sync_q[1]) begin
          state_d = DATA;
          bcnt_d  = '0;
        end
        DATA: begin
          shift_d = {dat_sync_q[1], shift_q[7:1]};
          bcnt_d  = bcnt_q + 1'b1;
          if (bcnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = dat_sync_q[1];
          state_d = STOP;
        end
        STOP: begin
          stop_d  = dat_sync_q[1];
          done_d  = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    // Byte step runs one cycle after the stop bit so the event lands two cycles after its fe.
    if (done_q) begin
      if (!frame_ok) begin
        err_d  = 1'b1;
        ext_d  = 1'b0;
        brk_d  = 1'b0;
        skip_d = '0;
      end else if (skip_q != 3'd0) begin
        skip_d = skip_q - 1'b1;
      end else begin
        case (shift_q)
          8'hE1: begin
            skip_d = 3'd7;
            ext_d  = 1'b0;
            brk_d  = 1'b0;
          end
          8'hE0: ext_d = 1'b1;
          8'hF0: brk_d = 1'b1;
          8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF: begin
            ext_d = 1'b0;
            brk_d = 1'b0;
          end
          default: begin
            code_d = {ext_q, brk_q, shift_q};
            rdy_d  = 1'b1;
            ext_d  = 1'b0;
            brk_d  = 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      filt_q     <= 1'b1;
      fcnt_q     <= '0;
      state_q    <= IDLE;
      bcnt_q     <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      stop_q     <= 1'b0;
      done_q     <= 1'b0;
      tcnt_q     <= '0;
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      skip_q     <= '0;
      code_q     <= '0;
      rdy_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk};
      dat_sync_q <= {dat_sync_q[0], ps2_dat};
      filt_q     <= filt_d;
      fcnt_q     <= fcnt_d;
      state_q    <= state_d;
      bcnt_q     <= bcnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      stop_q     <= stop_d;
      done_q     <= done_d;
      tcnt_q     <= tcnt_d;
      ext_q      <= ext_d;
      brk_q      <= brk_d;
      skip_q     <= skip_d;
      code_q     <= code_d;
      rdy_q      <= rdy_d;
      err_q      <= err_d;
    end
  end

  assign code_ready = rdy_q;
  assign scancode   = code_q;
  assign frame_err  = err_q;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Bench for ps2_scancode_rx: directed and random PS/2 frames checked against an
// event-queue model of the scancode rules, including event timing.
module tb_ps2_scancode_rx;
  localparam int FLEN = 8;
  localparam int TMO  = 600;
  localparam int HP   = 30;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic       code_ready, frame_err;
  logic [9:0] scancode;

  typedef struct {
    int          kind;  // 1 = code_ready, 2 = frame_err
    logic [9:0]  code;
    int unsigned at;
  } ev_t;

  ev_t         obs_q[$];
  ev_t         exp_q[$];
  int unsigned cyc = 0;
  int unsigned last_fall = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  bit          m_ext = 1'b0, m_brk = 1'b0;
  int          m_skip = 0;
  logic [9:0]  m_sc = 10'h000;
  logic        prev_strobe = 1'b0;

  ps2_scancode_rx #(.FILTER_LEN(FLEN), .TIMEOUT(TMO)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ps2_clk    (ps2_clk),
    .ps2_dat    (ps2_dat),
    .code_ready (code_ready),
    .scancode   (scancode),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (code_ready || frame_err) begin
      chk("strobe_spacing", {30'd0, prev_strobe, code_ready & frame_err}, 32'd0);
      obs_q.push_back('{code_ready ? 1 : 2, scancode, cyc});
    end
    prev_strobe = code_ready | frame_err;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Raw falling edge at cycle d -> 2 sync stages + FLEN filter cycles -> fe in cycle d+FLEN+1.
  // The event strobe follows that fe by 2 cycles.
  task automatic model_frame(input logic [7:0] b, input bit ok, input int unsigned fall_at);
    int unsigned t;
    t = fall_at + FLEN + 3;
    if (!ok) begin
      m_ext = 0; m_brk = 0; m_skip = 0;
      exp_q.push_back('{2, 10'h000, t});
    end else if (m_skip > 0) begin
      m_skip--;
    end else if (b == 8'hE1) begin
      m_skip = 7; m_ext = 0; m_brk = 0;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else if (b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF}) begin
      m_ext = 0; m_brk = 0;
    end else begin
      m_sc = {m_ext, m_brk, b};
      exp_q.push_back('{1, m_sc, t});
      m_ext = 0; m_brk = 0;
    end
  endtask

  task automatic compare_events(input string tag);
    int n;
    chk({tag, "_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_kind"}, obs_q[i].kind, exp_q[i].kind);
      chk({tag, "_cycle"}, obs_q[i].at, exp_q[i].at);
      if (exp_q[i].kind == 1) chk({tag, "_code"}, {22'd0, obs_q[i].code}, {22'd0, exp_q[i].code});
    end
    chk({tag, "_hold"}, {22'd0, scancode}, {22'd0, m_sc});
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic send_bit(input logic b);
    ps2_dat = b;
    wait_cyc(HP);
    ps2_clk = 1'b0;
    last_fall = cyc;
    wait_cyc(HP);
    ps2_clk = 1'b1;
  endtask

  task automatic glitch();
    ps2_clk = 1'b0;
    wait_cyc(FLEN - 1);
    ps2_clk = 1'b1;
    wait_cyc(12);
  endtask

  task automatic send_frame(input string tag, input logic [7:0] b, input bit bad_par,
                            input bit bad_stop, input int glitch_at);
    logic par;
    par = ~(^b) ^ bad_par;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      send_bit(b[i]);
      if (i == glitch_at) begin
        wait_cyc(20);
        glitch();
      end
    end
    send_bit(par);
    send_bit(~bad_stop);
    ps2_dat = 1'b1;
    model_frame(b, !bad_par && !bad_stop, last_fall);
    wait_cyc(HP);
    compare_events(tag);
  endtask

  initial begin
    #(10 * 95000);
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [7:0] specials [8];
    logic [7:0] b;
    int unsigned t0;
    specials = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF};

    wait_cyc(5);
    chk("rst_ready", {31'd0, code_ready}, 32'd0);
    chk("rst_err", {31'd0, frame_err}, 32'd0);
    chk("rst_code", {22'd0, scancode}, 32'd0);
    reset_n = 1'b1;
    wait_cyc(20);

    glitch();
    send_frame("f1c", 8'h1C, 0, 0, -1);

    send_frame("pre_e0", 8'hE0, 0, 0, -1);
    send_frame("pre_f0", 8'hF0, 0, 0, -1);
    send_frame("ext_brk", 8'h75, 0, 0, -1);
    send_frame("plain12", 8'h12, 0, 0, -1);

    send_frame("bad_par", 8'h1C, 1, 0, -1);
    send_frame("after_par", 8'h1C, 0, 0, -1);
    send_frame("bad_stop", 8'h33, 0, 1, -1);

    send_frame("pause_f0", 8'hF0, 0, 0, -1);
    foreach (specials[i]) begin end
    begin
      logic [7:0] pause_seq [8];
      pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
      for (int i = 0; i < 8; i++) send_frame("pause", pause_seq[i], 0, 0, -1);
    end
    send_frame("after_pause", 8'h29, 0, 0, -1);

    glitch();
    send_frame("glitch_mid", 8'h3B, 0, 0, 3);

    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(i[0]);
    t0 = last_fall;
    m_ext = 0; m_brk = 0; m_skip = 0;
    exp_q.push_back('{2, 10'h000, t0 + FLEN + 1 + TMO});
    wait_cyc(TMO + 40);
    compare_events("timeout");
    send_frame("after_tmo", 8'h5A, 0, 0, -1);

    send_frame("pre_rst", 8'hE0, 0, 0, -1);
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    wait_cyc(5);
    reset_n = 1'b0;
    #1;
    chk("midrst_ready", {31'd0, code_ready}, 32'd0);
    chk("midrst_err", {31'd0, frame_err}, 32'd0);
    chk("midrst_code", {22'd0, scancode}, 32'd0);
    wait_cyc(3);
    reset_n = 1'b1;
    m_ext = 0; m_brk = 0; m_skip = 0; m_sc = 10'h000;
    compare_events("midrst");
    wait_cyc(20);
    send_frame("after_rst", 8'h66, 0, 0, -1);

    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(0, 9))
        0:       b = 8'hE0;
        1:       b = 8'hF0;
        2:       b = specials[$urandom_range(0, 7)];
        3:       b = ($urandom_range(0, 2) == 0) ? 8'hE1 : 8'h5A;
        default: b = 8'($urandom);
      endcase
      send_frame("rand", b, $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
